mem_byte_responder: RTL and testbench

//  Memory responder serving fetch/load/store requests from the control FSM.
//  One 32-bit access is serialised over an internal 8-bit-wide byte array, one byte per clock.
//  It uses the same busy/done style as the nibble-serial ALU.

---
 rtl/mem_byte_responder_pkg.sv | 37 +++
 rtl/mem_byte_responder_if.sv | 24 ++
 rtl/mem_byte_responder_load_extender.sv | 22 ++
 rtl/mem_byte_responder.sv | 142 ++++++++++++++
 tb/tb_mem_byte_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_byte_responder_pkg.sv
// Shared types for the memory path: funct3 load/store widths and width helpers.
package mem_byte_responder_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;

  // RV32 load/store funct3 encodings.
  typedef enum logic [2:0] {
    BITS8   = 3'b000,
    BITS16  = 3'b001,
    BITS32  = 3'b010,
    BITS8U  = 3'b100,
    BITS16U = 3'b101
  } mem_width_e;

  function automatic logic width_legal(funct3_t w);
    return w inside {BITS8, BITS16, BITS32, BITS8U, BITS16U};
  endfunction

  // Index of the last byte of an access (N-1).
  function automatic logic [1:0] width_last_idx(funct3_t w);
    case (w)
      BITS16, BITS16U: return 2'd1;
      BITS32:          return 2'd3;
      default:         return 2'd0;
    endcase
  endfunction

  function automatic logic width_aligned(funct3_t w, logic [1:0] a);
    case (w)
      BITS16, BITS16U: return ~a[0];
      BITS32:          return (a == 2'b00);
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_responder_if.sv
// Request/response bundle between the control FSM (master) and the memory responder (slave).
interface mem_byte_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [2:0]        width;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req, we, width, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  req, we, width, addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/mem_byte_responder_load_extender.sv
// Sign/zero extension of an assembled little-endian load word.
module mem_byte_responder_load_extender
  import mem_byte_responder_pkg::*;
(
  input  logic [31:0] raw,
  input  mem_width_e  width,
  output logic [31:0] word
);

  // Extend from bit 7 or bit 15 depending on the access width.
  always_comb begin
    word = raw;
    case (width)
      BITS8:   word = {{24{raw[7]}}, raw[7:0]};
      BITS8U:  word = {24'h0, raw[7:0]};
      BITS16:  word = {{16{raw[15]}}, raw[15:0]};
      BITS16U: word = {16'h0, raw[15:0]};
      default: word = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_responder.sv
// Byte-serial memory responder: one 32-bit access moves over an 8-bit array, one byte per clock.
module mem_byte_responder
  import mem_byte_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  mem_byte_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [7:0] mem [DEPTH];

  logic [1:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            we_q, we_d;
  logic [2:0]      width_q, width_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] mem_idx;
  logic [31:0]     asm_next;
  logic [31:0]     ext_word;
  logic            unused_addr_hi;

  // Only the low index bits address the array; upper address bits alias.
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IdxW];

  assign mem_idx = idx_q + IdxW'(cnt_q);

  // Drop the current array byte into its little-endian slot of the assembly word.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt_q, 3'b000} +: 8] = mem[mem_idx];
  end

  mem_byte_responder_load_extender u_load_extender (
    .raw   (asm_next),
    .width (mem_width_e'(width_q)),
    .word  (ext_word)
  );

  // Next-state and datapath updates for IDLE -> XFER -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    width_d = width_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          idx_d   = bus.addr[IdxW-1:0];
          we_d    = bus.we;
          width_d = bus.width;
          wdata_d = bus.wdata;
          cnt_d   = 2'd0;
          asm_d   = 32'h0;
          if (width_legal(bus.width) && width_aligned(bus.width, bus.addr[1:0])) begin
            state_d = StXfer;
            err_d   = 1'b0;
          end else begin
            // Illegal or misaligned: complete immediately without touching the array.
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StXfer: begin
        if (!we_q) begin
          asm_d = asm_next;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == width_last_idx(width_q)) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = ext_word;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      width_q <= 3'b000;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store byte write; array is never reset, and reset forces StIdle so no write follows.
  always_ff @(posedge clk) begin
    if (state_q == StXfer && we_q) begin
      mem[mem_idx] <= wdata_q[{cnt_q, 3'b000} +: 8];
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_byte_responder.sv
// Scoreboard bench for mem_byte_responder: expectations queued on issue, checked on done.
module tb_mem_byte_responder;

  logic clk;
  logic rst;

  mem_byte_responder_if #(.ADDR_W(32)) bus ();

  mem_byte_responder #(
    .DEPTH  (256),
    .ADDR_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  exp_t sb [$];

  int          vectors;
  int          miscompares;
  logic [31:0] model_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for a single accept edge and queue what it must produce.
  task automatic issue(input logic w_e, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_busy);
    exp_t e;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w_e;
    bus.width = w;
    bus.addr  = a;
    bus.wdata = d;
    e.err   = exp_err;
    e.rdata = exp_rd;
    e.busy  = exp_busy;
    sb.push_back(e);
    @(negedge clk);
    bus.req   = 1'b0;
    bus.we    = 1'bx;
    bus.width = 3'bxxx;
    bus.addr  = 32'hxxxx_xxxx;
    bus.wdata = 32'hxxxx_xxxx;
  endtask

  // Count busy cycles until done (bounded), capture outputs, then sample done one cycle later.
  task automatic wait_done(output bit got, output int busy_n, output logic [31:0] rd,
                           output logic er, output logic again);
    got    = 1'b0;
    busy_n = 0;
    rd     = 32'hx;
    er     = 1'bx;
    again  = 1'bx;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        rd  = bus.rdata;
        er  = bus.err;
      end else begin
        @(negedge clk);
      end
    end
    if (got) begin
      @(negedge clk);
      again = bus.done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    vectors++;
    if (bus.rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
    end
    model_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    bit got; int bn; logic [31:0] rd; logic er; logic again; exp_t e;
    model_rdata = 32'hF234_5678;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, model_rdata, 5);
    wait_done(got, bn, rd, er, again);
    e = sb.pop_front();
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL lw_done: no done within 20 cycles");
    end else begin
      vectors++;
      if (rd !== e.rdata) begin
        miscompares++; $display("FAIL lw_rdata: got %h want %h", rd, e.rdata);
      end
      vectors++;
      if (er !== e.err) begin
        miscompares++; $display("FAIL lw_err: got %b want %b", er, e.err);
      end
      vectors++;
      if (bn !== e.busy) begin
        miscompares++; $display("FAIL lw_busy_cycles: got %0d want %0d", bn, e.busy);
      end
      vectors++;
      if (again !== 1'b0) begin
        miscompares++; $display("FAIL lw_done_pulse: done still %b next cycle want 0", again);
      end
    end
  endtask

  task automatic test_subword();
    logic [2:0]  w   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a   [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exr [4] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'hFFFF_F234, 32'h0000_5678};
    int          exb [4] = '{2, 2, 3, 3};
    bit got; int bn; logic [31:0] rd; logic er; logic again; exp_t e;
    for (int i = 0; i < 4; i++) begin
      model_rdata = exr[i];
      issue(1'b0, w[i], a[i], 32'h0, 1'b0, model_rdata, exb[i]);
      wait_done(got, bn, rd, er, again);
      e = sb.pop_front();
      vectors++;
      if (got !== 1'b1) begin
        miscompares++; $display("FAIL sub%0d_done: no done within 20 cycles", i);
      end else begin
        vectors++;
        if (rd !== e.rdata) begin
          miscompares++; $display("FAIL sub%0d_rdata: got %h want %h", i, rd, e.rdata);
        end
        vectors++;
        if (er !== e.err) begin
          miscompares++; $display("FAIL sub%0d_err: got %b want %b", i, er, e.err);
        end
        vectors++;
        if (bn !== e.busy) begin
          miscompares++; $display("FAIL sub%0d_busy: got %0d want %0d", i, bn, e.busy);
        end
      end
    end
  endtask

  task automatic test_store();
    logic        we  [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  w   [3] = '{3'b010, 3'b101, 3'b000};
    logic [31:0] a   [3] = '{32'h20, 32'h22, 32'h21};
    logic [31:0] d   [3] = '{32'hDEAD_BEEF, 32'h0, 32'h0000_0055};
    int          exb [3] = '{5, 3, 2};
    logic [7:0]  exm [5] = '{8'hEF, 8'h55, 8'hAD, 8'hDE, 8'hC4};
    bit got; int bn; logic [31:0] rd; logic er; logic again; exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!we[i]) model_rdata = 32'h0000_DEAD;
      issue(we[i], w[i], a[i], d[i], 1'b0, model_rdata, exb[i]);
      wait_done(got, bn, rd, er, again);
      e = sb.pop_front();
      vectors++;
      if (got !== 1'b1) begin
        miscompares++; $display("FAIL st%0d_done: no done within 20 cycles", i);
      end else begin
        vectors++;
        if (rd !== e.rdata) begin
          miscompares++; $display("FAIL st%0d_rdata: got %h want %h", i, rd, e.rdata);
        end
        vectors++;
        if (er !== e.err) begin
          miscompares++; $display("FAIL st%0d_err: got %b want %b", i, er, e.err);
        end
        vectors++;
        if (bn !== e.busy) begin
          miscompares++; $display("FAIL st%0d_busy: got %0d want %0d", i, bn, e.busy);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut.mem[8'h20 + i] !== exm[i]) begin
        miscompares++;
        $display("FAIL st_mem[%h]: got %h want %h", 8'h20 + i, dut.mem[8'h20 + i], exm[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0]  w [3] = '{3'b010, 3'b011, 3'b001};
    logic [31:0] a [3] = '{32'h11, 32'h10, 32'h13};
    bit got; int bn; logic [31:0] rd; logic er; logic again; exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, w[i], a[i], 32'h0, 1'b1, model_rdata, 1);
      wait_done(got, bn, rd, er, again);
      e = sb.pop_front();
      vectors++;
      if (got !== 1'b1) begin
        miscompares++; $display("FAIL err%0d_done: no done within 20 cycles", i);
      end else begin
        vectors++;
        if (er !== e.err) begin
          miscompares++; $display("FAIL err%0d_err: got %b want %b", i, er, e.err);
        end
        vectors++;
        if (rd !== e.rdata) begin
          miscompares++; $display("FAIL err%0d_rdata: got %h want %h", i, rd, e.rdata);
        end
        vectors++;
        if (bn !== e.busy) begin
          miscompares++; $display("FAIL err%0d_busy: got %0d want %0d", i, bn, e.busy);
        end
        vectors++;
        if (bus.err !== 1'b0) begin
          miscompares++; $display("FAIL err%0d_err_clear: got %b want 0", i, bus.err);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exm [4] = '{8'h44, 8'h33, 8'hA2, 8'hA3};
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.width = 3'b010;
    bus.addr  = 32'h30;
    bus.wdata = 32'h1122_3344;
    @(posedge clk);          // accept edge
    #1 bus.req = 1'b0;
    @(posedge clk);          // transfer edge 1
    @(posedge clk);          // transfer edge 2
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_done: got %b want 0", bus.done);
    end
    model_rdata = 32'h0;
    vectors++;
    if (bus.rdata !== model_rdata) begin
      miscompares++; $display("FAIL rstmid_rdata: got %h want %h", bus.rdata, model_rdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dut.mem[8'h30 + i] !== exm[i]) begin
        miscompares++;
        $display("FAIL rstmid_mem[%h]: got %h want %h", 8'h30 + i, dut.mem[8'h30 + i], exm[i]);
      end
    end
  endtask

  task automatic test_wrap_hold();
    bit got; int bn; logic [31:0] rd; logic er; logic again; exp_t e;
    int dones; int late_dones; int late_busy; bit seen;
    model_rdata = 32'hF234_5678;
    issue(1'b0, 3'b010, 32'h110, 32'h0, 1'b0, model_rdata, 5);
    wait_done(got, bn, rd, er, again);
    e = sb.pop_front();
    vectors++;
    if (got !== 1'b1) begin
      miscompares++; $display("FAIL wrap_done: no done within 20 cycles");
    end else begin
      vectors++;
      if (rd !== e.rdata) begin
        miscompares++; $display("FAIL wrap_rdata: got %h want %h", rd, e.rdata);
      end
    end
    // Held req: exactly one transaction, req dropped when done is seen.
    dut.mem[8'h10] = 8'h01;
    model_rdata = 32'hF234_5601;
    e.err = 1'b0; e.rdata = model_rdata; e.busy = 5;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.width = 3'b010; bus.addr = 32'h10; bus.wdata = 32'h0;
    sb.push_back(e);
    dones = 0; seen = 1'b0; rd = 32'hx;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++; seen = 1'b1; rd = bus.rdata;
        bus.req = 1'b0;
      end
    end
    e = sb.pop_front();
    late_dones = 0; late_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) late_dones++;
      if (bus.busy === 1'b1) late_busy++;
    end
    vectors++;
    if (dones !== 1) begin
      miscompares++; $display("FAIL hold_dones: got %0d want 1", dones);
    end
    vectors++;
    if (rd !== e.rdata) begin
      miscompares++; $display("FAIL hold_rdata: got %h want %h", rd, e.rdata);
    end
    vectors++;
    if (late_dones !== 0) begin
      miscompares++; $display("FAIL hold_dup_done: got %0d want 0", late_dones);
    end
    vectors++;
    if (late_busy !== 0) begin
      miscompares++; $display("FAIL hold_idle_busy: got %0d want 0", late_busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.width = 3'b000;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    dut.mem[8'h10] = 8'h78;
    dut.mem[8'h11] = 8'h56;
    dut.mem[8'h12] = 8'h34;
    dut.mem[8'h13] = 8'hF2;
    for (int i = 0; i < 5; i++) dut.mem[8'h20 + i] = 8'hC0 + 8'(i);
    for (int i = 0; i < 4; i++) dut.mem[8'h30 + i] = 8'hA0 + 8'(i);
    test_reset();
    test_lw();
    test_subword();
    test_store();
    test_errors();
    test_reset_mid();
    test_wrap_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
